// File: rtl/uart_rx128_assembler_if.sv
// Serial-in / word-out bundle for the 128-bit UART assembler.
// The receiver takes the slave view; the line driver / consumer takes the master view.
interface uart_rx128_assembler_if;
    logic         uart_rx;
    logic [127:0] rx_data;
    logic         rx_irq;
    logic         frame_err;
    logic         busy;

    modport master (output uart_rx, input rx_data, rx_irq, frame_err, busy);
    modport slave  (input uart_rx, output rx_data, rx_irq, frame_err, busy);
endinterface

// File: rtl/uart_rx128_assembler.sv
// 8N1 UART receiver that packs 16 bytes, first byte in [127:120], into a 128-bit word.
// A partial word is dropped on a framing error or after TIMEOUT_CLKS idle clocks.
module uart_rx128_assembler #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CLKS = 50000000
) (
    input  logic                   clock,
    input  logic                   reset,
    uart_rx128_assembler_if.slave  bus
);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t       r_state;
    logic [1:0]   r_sync;
    logic [15:0]  r_cnt;
    logic [2:0]   r_bit_idx;
    logic [7:0]   r_shift;
    logic [4:0]   r_byte_cnt;
    logic [127:0] r_word;
    logic [31:0]  r_tmo;
    logic [127:0] r_rx_data;
    logic         r_rx_irq;
    logic         r_frame_err;
    logic         w_rx;

    assign w_rx          = r_sync[1];
    assign bus.rx_data   = r_rx_data;
    assign bus.rx_irq    = r_rx_irq;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = (r_state != IDLE) || (r_byte_cnt != 5'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_sync      <= 2'b11;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_byte_cnt  <= '0;
            r_word      <= '0;
            r_tmo       <= '0;
            r_rx_data   <= '0;
            r_rx_irq    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], bus.uart_rx};
            r_rx_irq    <= 1'b0;
            r_frame_err <= 1'b0;

            // Count of 16 marks a finished word; publish it one edge after the last byte.
            if (r_byte_cnt == 5'd16) begin
                r_rx_data  <= r_word;
                r_rx_irq   <= 1'b1;
                r_byte_cnt <= '0;
            end

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx) r_state <= START;
                end
                START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= w_rx ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (r_cnt == FULL_LAST) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) r_state <= STOP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (r_cnt == FULL_LAST) begin
                        r_cnt <= '0;
                        if (w_rx) begin
                            r_word     <= {r_word[119:0], r_shift};
                            r_byte_cnt <= r_byte_cnt + 5'd1;
                            r_state    <= IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_byte_cnt  <= '0;
                            r_word      <= '0;
                            r_state     <= BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                BREAK: begin
                    if (w_rx) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            // Idle timer runs only between bytes of a partial word; a start bit restarts it.
            if (r_state == IDLE && w_rx && r_byte_cnt != 5'd0 && r_byte_cnt != 5'd16) begin
                if (r_tmo == TMO_LAST) begin
                    r_tmo      <= '0;
                    r_byte_cnt <= '0;
                    r_word     <= '0;
                end else begin
                    r_tmo <= r_tmo + 32'd1;
                end
            end else begin
                r_tmo <= '0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx128_assembler.sv
// Directed bench: stimulus pushes expected words into a queue, a negedge monitor pops on rx_irq.
module tb_uart_rx128_assembler;
    localparam int CPB = 16;
    localparam int TMO = 400;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   fe_seen = 0;
    logic [127:0] exp_q[$];

    uart_rx128_assembler_if bus ();

    uart_rx128_assembler #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // Monitor / scoreboard
    always @(negedge clock) begin
        if (bus.frame_err) fe_seen++;
        if (bus.rx_irq && bus.frame_err) begin
            errors++;
            $display("FAIL irq_fe_overlap: rx_irq and frame_err both high at %0t", $time);
        end
        if (bus.rx_irq) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_irq: rx_data=%h, no word expected", bus.rx_data);
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                if (bus.rx_data !== e) begin
                    errors++;
                    $display("FAIL word: got %h expected %h", bus.rx_data, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bus.uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rx = b[i];
            tick(CPB);
        end
        bus.uart_rx = stop;
        tick(CPB);
    endtask

    task automatic send_seq(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) send_byte(base + 8'(i), 1'b1);
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_drained(input string name, input int fe_exp);
        tick(20);
        check({name, "_pending"}, 128'(exp_q.size()), 128'd0);
        check({name, "_frame_err"}, 128'(fe_seen), 128'(fe_exp));
    endtask

    initial begin
        bus.uart_rx = 1'b1;
        tick(3);
        check("reset_rx_data", bus.rx_data, 128'd0);
        check("reset_irq", 128'(bus.rx_irq), 128'd0);
        check("reset_fe", 128'(bus.frame_err), 128'd0);
        check("reset_busy", 128'(bus.busy), 128'd0);
        reset = 1'b0;
        tick(5);

        // 16 bytes 0x00..0x0F
        exp_q.push_back(128'h000102030405060708090A0B0C0D0E0F);
        send_seq(8'h00, 16);
        check_drained("word0", 0);
        check("busy_after_word", 128'(bus.busy), 128'd0);

        // 4-clock glitch
        bus.uart_rx = 1'b0;
        tick(4);
        bus.uart_rx = 1'b1;
        begin
            int n;
            n = 0;
            while (n < 10 && bus.busy !== 1'b0) begin tick(1); n++; end
            check("glitch_busy", 128'(bus.busy), 128'd0);
        end
        check_drained("glitch", 0);
        check("glitch_rx_data_held", bus.rx_data, 128'h000102030405060708090A0B0C0D0E0F);

        // 3 good bytes, a bad stop bit, then a full word
        send_seq(8'h55, 3);
        send_byte(8'h77, 1'b0);
        bus.uart_rx = 1'b1;
        tick(32);
        check("fe_rx_data_held", bus.rx_data, 128'h000102030405060708090A0B0C0D0E0F);
        exp_q.push_back(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        send_seq(8'hA0, 16);
        check_drained("frame_err", 1);

        // 5 bytes, long idle (timeout), then a full word
        send_seq(8'h40, 5);
        tick(500);
        check("timeout_busy", 128'(bus.busy), 128'd0);
        check("timeout_rx_data_held", bus.rx_data, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        exp_q.push_back(128'h101112131415161718191A1B1C1D1E1F);
        send_seq(8'h10, 16);
        check_drained("timeout", 1);

        // reset in the data bits of byte 8
        send_seq(8'h60, 7);
        bus.uart_rx = 1'b0;
        tick(CPB);
        bus.uart_rx = 1'b1;
        tick(CPB * 3);
        reset = 1'b1;
        bus.uart_rx = 1'b1;
        tick(3);
        check("rst_rx_data", bus.rx_data, 128'd0);
        check("rst_irq", 128'(bus.rx_irq), 128'd0);
        check("rst_fe", 128'(bus.frame_err), 128'd0);
        check("rst_busy", 128'(bus.busy), 128'd0);
        reset = 1'b0;
        tick(40);
        exp_q.push_back(128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
        send_seq(8'hF0, 16);
        check_drained("midreset", 1);

        // 32 bytes back-to-back
        exp_q.push_back(128'h202122232425262728292A2B2C2D2E2F);
        exp_q.push_back(128'h303132333435363738393A3B3C3D3E3F);
        send_seq(8'h20, 32);
        check_drained("b2b", 1);
        check("b2b_rx_data_held", bus.rx_data, 128'h303132333435363738393A3B3C3D3E3F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx128_assembler.md
UART_RX128_ASSEMBLER -- requirements
Module: uart_rx128_assembler

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clock cycles per UART bit (50 MHz / 115200); legal range 8..65535.
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 50000000, meaning idle clocks after which a partial word is discarded; legal range is at least 2*CLKS_PER_BIT.
REQ-003 SHALL have port clock, input, 1 bit: clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port uart_rx, input, 1 bit: asynchronous serial line, 8N1, idle high.
REQ-006 SHALL have port rx_data, output, 128 bits: last complete assembled word.
REQ-007 SHALL have port rx_irq, output, 1 bit: one-cycle pulse when rx_data is updated.
REQ-008 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a stop-bit error.
REQ-009 SHALL have port busy, output, 1 bit: high while the FSM is not IDLE or a word is partially assembled.

Function
REQ-010 SHALL pass uart_rx through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK, with one bit counter of at least 16 bits.
REQ-012 IDLE: on synced line = 0, the FSM SHALL go to START and clear the bit counter.
REQ-013 START: at count CLKS_PER_BIT/2-1 (integer division), the FSM SHALL sample the line.
- Line = 0: go to DATA and clear the counter.
- Line = 1: treat as a glitch and return to IDLE with no output effect.
REQ-014 DATA: the FSM SHALL sample every CLKS_PER_BIT clocks, store 8 bits LSB first, then go to STOP.
REQ-015 STOP: after CLKS_PER_BIT clocks, the FSM SHALL sample the line.
- Line = 1: accept the byte and go to IDLE.
- Line = 0: pulse frame_err for 1 cycle, discard the byte, clear the byte count and partial word, and go to BREAK.
REQ-016 BREAK: the FSM SHALL wait until synced line = 1, then go to IDLE.
REQ-017 Word assembly SHALL be big-endian by arrival order.
- Each accepted byte shifts the 128-bit assembly register left 8 bits and enters at [7:0].
- The first byte of a word ends in [127:120].
REQ-018 On acceptance of the 16th byte, the block SHALL do the following on the next clock edge:
- Load rx_data with the assembled word.
- Assert rx_irq for exactly 1 cycle.
- Clear the byte count to 0.
REQ-019 rx_data SHALL hold its value until the next complete word; partial words, errors and timeouts SHALL never alter it.
REQ-020 Timeout: while in IDLE with byte count != 0, the block SHALL count idle clocks and reset the count on each start bit.
- At TIMEOUT_CLKS idle clocks, it SHALL discard the partial word and clear the byte count.
- A timeout SHALL produce no rx_irq and no frame_err.
REQ-021 busy SHALL be a registered or combinational function equal to (state != IDLE) OR (byte count != 0).
REQ-022 Back-to-back bytes with no idle gap SHALL be received without loss.
- A start edge detected in the cycle of return to IDLE is honoured.
REQ-023 rx_irq and frame_err SHALL never be asserted in the same cycle.

Reset
REQ-024 On reset the block SHALL set:
- rx_data = 0, rx_irq = 0, frame_err = 0, busy = 0.
- FSM = IDLE, byte count = 0, assembly register = 0, bit and timeout counters = 0.
- Synchronizer flops = 1.
REQ-025 Reset asserted mid-byte or mid-word SHALL abandon all partial data, with no rx_irq pulse during or after reset.

Verification (CLKS_PER_BIT = 16, TIMEOUT_CLKS = 400)
REQ-026 Send 16 bytes 0x00..0x0F -> exactly one rx_irq pulse; rx_data = 0x000102030405060708090A0B0C0D0E0F.
REQ-027 Glitch uart_rx low for 4 clocks -> no frame_err, no irq; busy returns to 0 within 10 clocks.
REQ-028 Send 3 good bytes, then 1 byte with stop = 0, then 16 bytes 0xA0..0xAF:
- frame_err pulses once.
- A single rx_irq follows, with rx_data = 0xA0A1...AF.
REQ-029 Send 5 bytes, idle 500 clocks, then 16 bytes 0x10..0x1F -> no irq after the first 5; a single irq with rx_data = 0x101112...1F.
REQ-030 Assert reset during the data bits of byte 8, then send 16 bytes 0xF0..0xFF:
- All outputs read 0 during reset.
- A single irq follows, with rx_data = 0xF0F1...FF.
REQ-031 Send 32 bytes back-to-back with no gap -> two irq pulses with first-word and second-word values; rx_data holds the second word afterwards.
